// File: rtl/dlx_shift_pkg.sv
// Shared types for the DLX pipelined shift unit.
package dlx_shift_pkg;

  // Operation codes of the SHIFT_REG instruction class; 110/111 are illegal.
  typedef enum logic [2:0] {
    OP_SLL = 3'b000,
    OP_SLA = 3'b001,
    OP_SRL = 3'b010,
    OP_SRA = 3'b011,
    OP_ROL = 3'b100,
    OP_ROR = 3'b101
  } shift_op_e;

  // Instruction class that routes ops to this unit.
  typedef enum logic [2:0] {
    CLASS_SHIFT_REG = 3'b000
  } instr_class_e;

  // Status side-band computed once from the original operand.
  typedef struct packed {
    logic carry;
    logic ovf;
    logic zero;
    logic illegal;
  } shift_flags_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    return op <= OP_ROR;
  endfunction

endpackage

// File: rtl/dlx_shift_layer.sv
// One combinational barrel-shifter layer: conditionally shifts/rotates by 2**LAYER.
module dlx_shift_layer
  import dlx_shift_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LAYER  = 0
) (
  input  logic [DATA_W-1:0] data,
  input  logic              shamt_bit,
  input  logic [2:0]        op,
  input  logic              sign,
  output logic [DATA_W-1:0] shifted
);

  localparam int K = 1 << LAYER;

  // Select the shifted/rotated form of the operand when this layer's amount bit is set.
  // NOTE: the default assignment first guarantees every path drives 'shifted', so no latch is inferred.
  always_comb begin
    shifted = data;
    if (shamt_bit) begin
      case (op)
        OP_SLL, OP_SLA: shifted = {data[DATA_W-1-K:0], {K{1'b0}}};
        OP_SRL:         shifted = {{K{1'b0}}, data[DATA_W-1:K]};
        OP_SRA:         shifted = {{K{sign}}, data[DATA_W-1:K]};
        OP_ROL:         shifted = {data[DATA_W-1-K:0], data[DATA_W-1:DATA_W-K]};
        OP_ROR:         shifted = {data[K-1:0], data[DATA_W-1:K]};
        default:        shifted = data;
      endcase
    end
  end

endmodule

// File: rtl/dlx_shift_pipe.sv
// Pipelined barrel-shift unit for the DLX execute stage, with global-stall backpressure.
module dlx_shift_pipe
  import dlx_shift_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int PIPE_STAGES = 1,
  parameter int TAG_W       = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  input  logic [$clog2(DATA_W)-1:0] in_shamt,
  input  logic [2:0]                in_op,
  input  logic [TAG_W-1:0]          in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [TAG_W-1:0]          out_tag,
  output logic                      out_carry,
  output logic                      out_ovf,
  output logic                      out_zero,
  output logic                      out_illegal
);

  localparam int SHAMT_W = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] ONES = '1;

  // Stage registers: index s is the register closing pipeline stage s.
  logic [PIPE_STAGES-1:0] st_valid;
  logic [DATA_W-1:0]      st_data  [PIPE_STAGES];
  logic [SHAMT_W-1:0]     st_shamt [PIPE_STAGES];
  logic [2:0]             st_op    [PIPE_STAGES];
  logic [TAG_W-1:0]       st_tag   [PIPE_STAGES];
  shift_flags_t           st_flags [PIPE_STAGES];

  logic [DATA_W-1:0] layer_out    [SHAMT_W];
  logic [DATA_W-1:0] stage_result [PIPE_STAGES];

  logic advance;
  logic accept;

  assign out_valid = st_valid[PIPE_STAGES-1];
  assign in_ready  = !(out_valid && !out_ready);
  assign advance   = in_ready;
  assign accept    = in_valid && in_ready && !flush;

  // Mux layers, each placed in stage floor(i*PIPE_STAGES/SHAMT_W).
  for (genvar i = 0; i < SHAMT_W; i++) begin : g_layer
    localparam int STG  = (i * PIPE_STAGES) / SHAMT_W;
    localparam bit FIRST = (i == 0) || ((((i - 1) * PIPE_STAGES) / SHAMT_W) != STG);
    localparam bit LAST  = (i == SHAMT_W - 1) || ((((i + 1) * PIPE_STAGES) / SHAMT_W) != STG);

    logic [DATA_W-1:0] lay_in;
    logic              shamt_bit;
    logic [2:0]        op_src;

    if (STG == 0) begin : g_ctl_in
      assign shamt_bit = in_shamt[i];
      assign op_src    = in_op;
    end else begin : g_ctl_reg
      assign shamt_bit = st_shamt[STG-1][i];
      assign op_src    = st_op[STG-1];
    end

    if (i == 0) begin : g_src_in
      assign lay_in = in_data;
    end else if (FIRST) begin : g_src_reg
      assign lay_in = st_data[STG-1];
    end else begin : g_src_chain
      assign lay_in = layer_out[i-1];
    end

    dlx_shift_layer #(
      .DATA_W (DATA_W),
      .LAYER  (i)
    ) u_layer (
      .data      (lay_in),
      .shamt_bit (shamt_bit),
      .op        (op_src),
      .sign      (lay_in[DATA_W-1]),
      .shifted   (layer_out[i])
    );

    if (LAST) begin : g_stage_end
      assign stage_result[STG] = layer_out[i];
    end
  end

  // Flag helpers derived from the untouched operand and shift amount.
  logic [DATA_W-1:0]  keep_left;    // operand bits that survive a left shift
  logic [DATA_W-1:0]  keep_right;   // operand bits that survive a right shift
  logic [DATA_W-1:0]  sign_field;   // top shamt+1 bits, which must agree for SLA
  logic [DATA_W-1:0]  sign_bits;
  logic [SHAMT_W-1:0] carry_idx_left;
  logic [SHAMT_W-1:0] carry_idx_right;
  shift_flags_t       in_flags;

  assign keep_left       = ONES >> in_shamt;
  assign keep_right      = ONES << in_shamt;
  assign sign_field      = ~((ONES >> 1) >> in_shamt);
  assign sign_bits       = in_data & sign_field;
  assign carry_idx_left  = -in_shamt;          // DATA_W - shamt, modulo DATA_W
  assign carry_idx_right = in_shamt - 1'b1;

  // Stage-0 flag evaluation; the flags then ride down the pipe with the op.
  always_comb begin
    in_flags = '0;
    case (in_op)
      OP_SLL, OP_SLA: begin
        in_flags.carry = (in_shamt != '0) && in_data[carry_idx_left];
        in_flags.zero  = (in_data & keep_left) == '0;
        if (in_op == OP_SLA) begin
          in_flags.ovf = (sign_bits != '0) && (sign_bits != sign_field);
        end
      end
      OP_SRL: begin
        in_flags.carry = (in_shamt != '0) && in_data[carry_idx_right];
        in_flags.zero  = (in_data & keep_right) == '0;
      end
      OP_SRA: begin
        in_flags.carry = (in_shamt != '0) && in_data[carry_idx_right];
        in_flags.zero  = !in_data[DATA_W-1] && ((in_data & keep_right) == '0);
      end
      OP_ROL, OP_ROR: begin
        in_flags.zero = in_data == '0;
      end
      default: begin
        in_flags.illegal = !is_legal_op(in_op);
      end
    endcase
  end

  // Pipeline registers: reset beats flush, flush kills everything, otherwise advance unless stalled.
  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  // NOTE: payload registers are reset too (not only valid bits) so the output is never X after reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      st_valid <= '0;
      for (int s = 0; s < PIPE_STAGES; s++) begin
        st_data[s]  <= '0;
        st_shamt[s] <= '0;
        st_op[s]    <= '0;
        st_tag[s]   <= '0;
        st_flags[s] <= '0;
      end
    end else if (flush) begin
      st_valid <= '0;
    end else if (advance) begin
      st_valid[0] <= accept;
      st_data[0]  <= stage_result[0];
      st_shamt[0] <= in_shamt;
      st_op[0]    <= in_op;
      st_tag[0]   <= in_tag;
      st_flags[0] <= in_flags;
      for (int s = 1; s < PIPE_STAGES; s++) begin
        st_valid[s] <= st_valid[s-1];
        st_data[s]  <= stage_result[s];
        st_shamt[s] <= st_shamt[s-1];
        st_op[s]    <= st_op[s-1];
        st_tag[s]   <= st_tag[s-1];
        st_flags[s] <= st_flags[s-1];
      end
    end
  end

  assign out_data    = st_data[PIPE_STAGES-1];
  assign out_tag     = st_tag[PIPE_STAGES-1];
  assign out_carry   = st_flags[PIPE_STAGES-1].carry;
  assign out_ovf     = st_flags[PIPE_STAGES-1].ovf;
  assign out_zero    = st_flags[PIPE_STAGES-1].zero;
  assign out_illegal = st_flags[PIPE_STAGES-1].illegal;

endmodule

// File: tb/tb_dlx_shift_pipe.sv
// Self-checking bench: a 1-stage and a 5-stage instance driven by shared stimulus,
// each compared cycle by cycle against an arithmetic reference and a delay-line model.
module tb_dlx_shift_pipe;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [2:0]  in_op;
  logic [4:0]  in_tag;
  logic        out_ready;

  logic [1:0]  i_ready;
  logic [1:0]  o_valid;
  logic [31:0] o_data [2];
  logic [4:0]  o_tag  [2];
  logic [1:0]  o_carry;
  logic [1:0]  o_ovf;
  logic [1:0]  o_zero;
  logic [1:0]  o_illegal;

  dlx_shift_pipe #(.DATA_W(32), .PIPE_STAGES(1), .TAG_W(5)) u_dut1 (
    .clk (clk), .reset (reset), .flush (flush),
    .in_valid (in_valid), .in_ready (i_ready[0]),
    .in_data (in_data), .in_shamt (in_shamt), .in_op (in_op), .in_tag (in_tag),
    .out_valid (o_valid[0]), .out_ready (out_ready),
    .out_data (o_data[0]), .out_tag (o_tag[0]),
    .out_carry (o_carry[0]), .out_ovf (o_ovf[0]), .out_zero (o_zero[0]),
    .out_illegal (o_illegal[0])
  );

  dlx_shift_pipe #(.DATA_W(32), .PIPE_STAGES(5), .TAG_W(5)) u_dut5 (
    .clk (clk), .reset (reset), .flush (flush),
    .in_valid (in_valid), .in_ready (i_ready[1]),
    .in_data (in_data), .in_shamt (in_shamt), .in_op (in_op), .in_tag (in_tag),
    .out_valid (o_valid[1]), .out_ready (out_ready),
    .out_data (o_data[1]), .out_tag (o_tag[1]),
    .out_carry (o_carry[1]), .out_ovf (o_ovf[1]), .out_zero (o_zero[1]),
    .out_illegal (o_illegal[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        vld;
    logic [31:0] data;
    logic [4:0]  tag;
    logic        carry;
    logic        ovf;
    logic        zero;
    logic        illegal;
  } slot_t;

  slot_t      pipe [2][5];   // [instance][age], age 0 = just accepted
  logic [1:0] post_reset;
  logic [1:0] last_acc;
  int         retired [2];
  int         n_checks;
  int         n_pass;

  function automatic int depth_of(input int k);
    return (k == 0) ? 1 : 5;
  endfunction

  function automatic string nm(input int k, input string what);
    return $sformatf("P%0d %s", depth_of(k), what);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
  endtask

  // Expected result of one op, from plain wide-word arithmetic.
  function automatic slot_t ref_op(input logic [31:0] d, input logic [4:0] s,
                                   input logic [2:0] op, input logic [4:0] tg);
    slot_t       r;
    logic [63:0] w;
    r     = '0;
    r.vld = 1'b1;
    r.tag = tg;
    case (op)
      3'd0, 3'd1: begin
        w       = {32'b0, d} << s;
        r.data  = w[31:0];
        r.carry = w[32];
        if (op == 3'd1) r.ovf = ($signed(w[31:0]) >>> s) != $signed(d);
      end
      3'd2: begin
        w       = {d, 32'b0} >> s;
        r.data  = w[63:32];
        r.carry = w[31];
      end
      3'd3: begin
        w       = $signed({d, 32'b0}) >>> s;
        r.data  = w[63:32];
        r.carry = w[31];
      end
      3'd4: begin
        w      = {d, d} << s;
        r.data = w[63:32];
      end
      3'd5: begin
        w      = {d, d} >> s;
        r.data = w[31:0];
      end
      default: begin
        r.data    = d;
        r.illegal = 1'b1;
      end
    endcase
    r.zero = (r.data == 32'd0) && !r.illegal;
    return r;
  endfunction

  function automatic logic [31:0] rand_data();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'h1 << $urandom_range(0, 31);
      default: return $urandom;
    endcase
  endfunction

  // One clock cycle: compare outputs, apply inputs, compare in_ready, advance the model.
  task automatic cycle(input logic v, input logic [31:0] d, input logic [4:0] s,
                       input logic [2:0] op, input logic [4:0] tg,
                       input logic rdy, input logic fl, input logic rs);
    slot_t h [2];
    logic  stall;
    for (int k = 0; k < 2; k++) begin
      h[k] = pipe[k][depth_of(k)-1];
      check(nm(k, "out_valid"), 32'(o_valid[k]), 32'(h[k].vld));
      if (h[k].vld) begin
        check(nm(k, "out_data"),    o_data[k],             h[k].data);
        check(nm(k, "out_tag"),     32'(o_tag[k]),         32'(h[k].tag));
        check(nm(k, "out_carry"),   32'(o_carry[k]),       32'(h[k].carry));
        check(nm(k, "out_ovf"),     32'(o_ovf[k]),         32'(h[k].ovf));
        check(nm(k, "out_zero"),    32'(o_zero[k]),        32'(h[k].zero));
        check(nm(k, "out_illegal"), 32'(o_illegal[k]),     32'(h[k].illegal));
      end
      if (post_reset[k]) begin
        check(nm(k, "reset out_data"), o_data[k], 32'd0);
        check(nm(k, "reset out_tag"), 32'(o_tag[k]), 32'd0);
        check(nm(k, "reset flags"),
              32'({o_carry[k], o_ovf[k], o_zero[k], o_illegal[k]}), 32'd0);
        post_reset[k] = 1'b0;
      end
    end
    in_valid  = v;
    in_data   = d;
    in_shamt  = s;
    in_op     = op;
    in_tag    = tg;
    out_ready = rdy;
    flush     = fl;
    reset     = rs;
    #1;
    for (int k = 0; k < 2; k++) begin
      stall = h[k].vld && !rdy;
      check(nm(k, "in_ready"), 32'(i_ready[k]), 32'(!stall));
      last_acc[k] = v && !stall && !fl && rs;
      if (h[k].vld && rdy) retired[k]++;
      if (!rs || fl) begin
        for (int j = 0; j < 5; j++) pipe[k][j] = '0;
        if (!rs) post_reset[k] = 1'b1;
      end else if (!stall) begin
        for (int j = 4; j > 0; j--) pipe[k][j] = pipe[k][j-1];
        pipe[k][0] = last_acc[k] ? ref_op(d, s, op, tg) : '0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 5'd0, 3'd0, 5'd0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    post_reset = 2'b11;
    last_acc   = 2'b00;
    retired[0] = 0;
    retired[1] = 0;
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 5; j++) pipe[k][j] = '0;
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_op     = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // Directed vectors, one per cycle with the consumer always ready.
    cycle(1'b1, 32'h8000_00F0, 5'd4,  3'd3, 5'd1, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 32'h4000_0001, 5'd1,  3'd1, 5'd2, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 32'h4000_0001, 5'd0,  3'd1, 5'd3, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 32'h0000_0001, 5'd1,  3'd5, 5'd4, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 32'h8000_0001, 5'd31, 3'd4, 5'd5, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 32'h1234_5678, 5'd7,  3'd6, 5'd6, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 32'h0000_0000, 5'd3,  3'd7, 5'd7, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 32'h0000_0010, 5'd5,  3'd2, 5'd8, 1'b1, 1'b0, 1'b1);
    idle(6);

    // Back-to-back SLL, tags 1..8, consumer not ready in cycles 3-6; the
    // issuer only moves on once the 5-stage unit has taken the op.
    retired[1] = 0;
    begin
      int idx;
      int c;
      idx = 1;
      c   = 1;
      while ((idx <= 8) && (c < 40)) begin
        cycle(1'b1, rand_data(), 5'($urandom_range(0, 31)), 3'd0, 5'(idx),
              !((c >= 3) && (c <= 6)), 1'b0, 1'b1);
        if (last_acc[1]) idx++;
        c++;
      end
      check("P5 all tags accepted", 32'(idx), 32'd9);
    end
    idle(8);
    check("P5 results retired", 32'(retired[1]), 32'd8);

    // Flush with three ops in flight and a fourth offered in the flush cycle.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, rand_data(), 5'(i + 1), 3'd2, 5'(20 + i), 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 32'hDEAD_BEEF, 5'd4, 3'd0, 5'd31, 1'b1, 1'b1, 1'b1);
    idle(6);

    // Reset asserted mid-stream.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, rand_data(), 5'(i + 2), 3'd4, 5'(10 + i), 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 32'hCAFE_F00D, 5'd1, 3'd1, 5'd15, 1'b1, 1'b0, 1'b0);
    idle(2);

    // Randomized traffic with backpressure, occasional flush and reset.
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 3) != 0, rand_data(), 5'($urandom_range(0, 31)),
            3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 99) != 0);
    idle(6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
